// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and encodings for the instruction fetch slice.
//   state_e     : fetch sequencer states (FAULT only reachable when
//                 FETCH_ALIGN_CHECK_EN is defined)
//   PCSEL_*     : next-PC select encodings driven by the decoder
//   OPC_J/JAL   : MIPS opcodes the decoder folds into the jump select
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    ISSUE = 2'b10,
    FAULT = 2'b11
  } state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BEQ = 2'b01;
  localparam logic [1:0] PCSEL_BNE = 2'b10;
  localparam logic [1:0] PCSEL_JR  = 2'b11;

  localparam logic [5:0] OPC_J   = 6'd2;
  localparam logic [5:0] OPC_JAL = 6'd3;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next program counter for a committing
// instruction.
//   pc         in  32  address of the committing instruction
//   instr      in  26  low instruction bits (jump index / branch offset);
//                      the opcode is already decoded into jump/pc_sel
//   pc_sel     in  2   sequential / BEQ / BNE / JR select
//   jump       in  1   J or JAL, overrides pc_sel
//   jr_target  in  32  register value for JR
//   next_pc    out 32  computed target, unaligned targets passed through
//   misaligned out 1   next_pc[1:0] is non-zero
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr,
  input  logic [1:0]  pc_sel,
  input  logic        jump,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] seq_s;
  logic [31:0] br_off_s;

  assign seq_s    = pc + 32'd4;
  // Word offset sign-extended and scaled to bytes.
  assign br_off_s = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Target selection; jump outranks every pc_sel value.
  always_comb begin
    next_pc = seq_s;
    if (jump) begin
      next_pc = {seq_s[31:28], instr[25:0], 2'b00};
    end else begin
      case (pc_sel)
        PCSEL_SEQ: next_pc = seq_s;
        PCSEL_BEQ,
        PCSEL_BNE: next_pc = seq_s + br_off_s;
        PCSEL_JR:  next_pc = jr_target;
        default:   next_pc = seq_s;
      endcase
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch sequencer between instruction memory and decode.
// Holds the PC, requests one word per instruction (req/ack), presents it
// until commit, then redirects via next_pc_calc.
//   clk, reset            clock and synchronous active-high reset
//   imem_req/addr/ack/data instruction memory handshake
//   instr/instr_valid/pc/link_addr  presented instruction
//   commit/pc_sel/jump/jr_target    commit and redirect controls
//   retired               wrapping count of committed instructions
//   fault                 misaligned-target fault
// Optional feature macro FETCH_ALIGN_CHECK_EN: when defined, a misaligned
// target enters a sticky FAULT state; otherwise targets are force-aligned
// and fault is tied low.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  input  logic        commit,
  input  logic [1:0]  pc_sel,
  input  logic        jump,
  input  logic [31:0] jr_target,
  output logic [31:0] retired,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] link_q, link_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] calc_pc_s;
  logic [31:0] target_s;
  logic        misaligned_s;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
`endif

  next_pc_calc u_next_pc_calc (
    .pc         (pc_q),
    .instr      (instr_q[25:0]),
    .pc_sel     (pc_sel),
    .jump       (jump),
    .jr_target  (jr_target),
    .next_pc    (calc_pc_s),
    .misaligned (misaligned_s)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_s = calc_pc_s;
`else
  // Only JR can produce low bits; drop them so fetches stay word-aligned.
  assign target_s = misaligned_s ? (calc_pc_s & 32'hFFFF_FFFC) : calc_pc_s;
`endif

  // Next-state, PC and counter update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    link_d    = link_q;
    instr_d   = instr_q;
    retired_d = retired_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (commit) begin
          pc_d      = target_s;
          link_d    = target_s + 32'd4;
          retired_d = retired_q + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
          if (misaligned_s) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
`else
          state_d = FETCH;
`endif
        end else begin
          state_d = ISSUE;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
    // Handshake outputs follow the upcoming state so they leave a flop.
    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      link_q    <= RESET_PC + 32'd4;
      instr_q   <= 32'h0000_0000;
      retired_q <= 32'h0000_0000;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      link_q    <= link_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign link_addr   = link_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch.
// The driver plays memory and execute stage and pushes expected fetch
// addresses / presented instructions; a negedge monitor pops and compares.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        commit;
  logic [1:0]  pc_sel;
  logic        jump;
  logic [31:0] jr_target;
  logic [31:0] retired;
  logic        fault;

  int          vecs = 0;
  int          errs = 0;
  logic        mon_en = 1'b0;
  logic        exp_fault = 1'b0;
  logic [31:0] mpc;
  logic [31:0] mr;
  logic [31:0] exp_a[$];
  logic [95:0] exp_i[$];
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_addr, h_instr, h_pc, h_link;
  logic [1:0]  r_sel;
  logic        r_j;
  logic [31:0] r_jr;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .link_addr(link_addr),
    .commit(commit), .pc_sel(pc_sel), .jump(jump), .jr_target(jr_target),
    .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC written from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic [1:0] sel, input logic j,
                                             input logic [31:0] jr);
    logic [31:0] seq;
    logic [31:0] n;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ins[15:0]));
    if (j)                n = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    else if (sel == 2'd3) n = jr;
    else if (sel == 2'd0) n = seq;
    else                  n = seq + 32'(off * 4);
`ifndef FETCH_ALIGN_CHECK_EN
    n = n & 32'hFFFF_FFFC;
`endif
    return n;
  endfunction

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    if (!imem_req) begin vecs++; errs++; $display("FAIL req_timeout: got 0 expected 1"); end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    if (!instr_valid) begin vecs++; errs++; $display("FAIL valid_timeout: got 0 expected 1"); end
  endtask

  // One full instruction: aw wait states in FETCH, cw stall cycles in ISSUE.
  task automatic do_instr(input int aw, input logic [31:0] data, input int cw,
                          input logic [1:0] sel, input logic j, input logic [31:0] jr,
                          input logic push_next);
    logic [31:0] nxt;
    wait_req();
    for (int i = 0; i < aw; i++) begin
      imem_ack  = 1'b0;
      commit    = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      pc_sel    = 2'($urandom);
      jump      = 1'($urandom);
      imem_data = $urandom;
      tick();
    end
    commit    = 1'b0;
    imem_ack  = 1'b1;
    imem_data = data;
    exp_i.push_back({data, mpc, mpc + 32'd4});
    tick();
    imem_ack = 1'b0;
    wait_valid();
    for (int i = 0; i < cw; i++) begin
      commit    = 1'b0;
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      pc_sel    = 2'($urandom);
      jump      = 1'($urandom);
      jr_target = $urandom;
      tick();
    end
    imem_ack  = 1'b0;
    commit    = 1'b1;
    pc_sel    = sel;
    jump      = j;
    jr_target = jr;
    nxt = model_next(mpc, data, sel, j, jr);
    tick();
    commit = 1'b0;
    mr     = mr + 32'd1;
    mpc    = nxt;
    if (push_next) exp_a.push_back(nxt);
  endtask

  // Monitor: compares presented outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] ea;
      logic [95:0] ei;
      chk("req_valid_overlap", {31'b0, imem_req & instr_valid}, 32'd0);
      if (imem_req) begin
        if (!prev_req) begin
          if (exp_a.size() == 0) begin
            vecs++; errs++; $display("FAIL fetch_unexpected: got %h expected none", imem_addr);
          end else begin
            ea = exp_a.pop_front();
            chk("fetch_addr", imem_addr, ea);
          end
          held_addr <= imem_addr;
        end else begin
          chk("addr_stable", imem_addr, held_addr);
        end
      end
      if (instr_valid) begin
        if (!prev_valid) begin
          if (exp_i.size() == 0) begin
            vecs++; errs++; $display("FAIL issue_unexpected: got %h expected none", instr);
          end else begin
            ei = exp_i.pop_front();
            chk("instr", instr, ei[95:64]);
            chk("pc", pc, ei[63:32]);
            chk("link_addr", link_addr, ei[31:0]);
          end
          h_instr <= instr;
          h_pc    <= pc;
          h_link  <= link_addr;
        end else begin
          chk("instr_stable", instr, h_instr);
          chk("pc_stable", pc, h_pc);
          chk("link_stable", link_addr, h_link);
        end
      end
      chk("retired", retired, mr);
      chk("fault", {31'b0, fault}, {31'b0, exp_fault});
      prev_req   <= imem_req;
      prev_valid <= instr_valid;
    end
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; commit = 1'b0;
    pc_sel = 2'b00; jump = 1'b0; jr_target = 32'h0;
    mpc = RST_PC; mr = 32'd0;
    repeat (3) tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_link", link_addr, RST_PC + 32'd4);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    exp_a.push_back(RST_PC);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("idle_no_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);

    // Sequential: 0,4,8,12 then retired=4.
    for (int k = 0; k < 4; k++) do_instr(0, $urandom, 0, 2'b00, 1'b0, $urandom, 1'b1);
    chk("seq_retired", retired, 32'd4);
    chk("seq_next_addr", imem_addr, 32'd16);

    // Wait states with an ignored commit pulse in FETCH.
    do_instr(5, $urandom, 0, 2'b00, 1'b0, 32'h0, 1'b1);

    // BEQ taken from 0x40 with offset -2 words.
    do_instr(0, $urandom, 1, 2'b11, 1'b0, 32'h0000_0040, 1'b1);
    do_instr(0, 32'h1234_FFFE, 0, 2'b01, 1'b0, 32'h0, 1'b1);
    chk("beq_addr", imem_addr, 32'h0000_003C);

    // JAL wins over JR.
    do_instr(0, $urandom, 0, 2'b11, 1'b0, 32'h1000_0010, 1'b1);
    do_instr(1, 32'h0C00_0100, 2, 2'b11, 1'b1, 32'hDEAD_BEE0, 1'b1);
    chk("jal_addr", imem_addr, 32'h1000_0400);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      r_sel = 2'($urandom_range(0, 3));
      r_j   = ($urandom_range(0, 3) == 0);
      r_jr  = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      r_jr  = r_jr & 32'hFFFF_FFFC;
`endif
      do_instr($urandom_range(0, 3), $urandom, $urandom_range(0, 3), r_sel, r_j, r_jr, 1'b1);
    end

    // Reset in ISSUE together with commit.
    wait_req();
    imem_ack  = 1'b1;
    imem_data = $urandom;
    exp_i.push_back({imem_data, mpc, mpc + 32'd4});
    tick();
    imem_ack = 1'b0;
    wait_valid();
    reset = 1'b1; commit = 1'b1; pc_sel = 2'b11; jump = 1'b1;
    tick();
    reset = 1'b0; commit = 1'b0;
    mr = 32'd0; mpc = RST_PC;
    exp_a.push_back(RST_PC);
    chk("rstiss_valid", {31'b0, instr_valid}, 32'd0);
    chk("rstiss_pc", pc, RST_PC);
    chk("rstiss_retired", retired, 32'd0);
    chk("rstiss_req0", {31'b0, imem_req}, 32'd0);
    tick();
    chk("rstiss_req1", {31'b0, imem_req}, 32'd1);

    for (int k = 0; k < 6; k++) do_instr($urandom_range(0, 2), $urandom, 0, 2'b00, 1'b0, 32'h0, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned JR target faults and stays faulted.
    do_instr(0, $urandom, 0, 2'b11, 1'b0, 32'h0000_0022, 1'b0);
    exp_fault = 1'b1;
    chk("fault_pc", pc, 32'h0000_0022);
    chk("fault_flag", {31'b0, fault}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      imem_ack = 1'($urandom_range(0, 1));
      commit   = 1'($urandom_range(0, 1));
      tick();
      chk("fault_no_req", {31'b0, imem_req}, 32'd0);
      chk("fault_no_valid", {31'b0, instr_valid}, 32'd0);
      chk("fault_sticky", {31'b0, fault}, 32'd1);
    end
    imem_ack = 1'b0; commit = 1'b0;
`else
    // Misaligned JR target is force-aligned.
    do_instr(0, $urandom, 0, 2'b11, 1'b0, 32'h0000_0022, 1'b1);
    chk("align_addr", imem_addr, 32'h0000_0020);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
